// File: rtl/md_buffer_pkg.sv
// Shared widths, queue indices and helpers for the metadata buffer stage.
package md_buffer_pkg;

  localparam int MD_W   = 9;
  localparam int MD2_W  = 16;
  localparam int DROP_W = 16;

  localparam int Q_TSN_EVEN = 0;
  localparam int Q_TSN_ODD  = 1;
  localparam int Q_RC       = 2;
  localparam int Q_BE       = 3;

  // Drop counters stick at all-ones so a flood never wraps back to a small value.
  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] value);
    return (value == '1) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/md_buffer_fifo.sv
// Single-clock FWFT FIFO with occupancy count and saturating overflow-drop counter.
module md_fifo
  import md_buffer_pkg::*;
#(
  parameter int WIDTH      = MD_W,
  parameter int DEPTH_LOG2 = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  wr,
  input  logic                  rd,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   usedw,
  output logic [DROP_W-1:0]     drop_cnt
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   cnt;
  logic                  pop;
  logic                  accept;
  logic                  overflow;

  assign empty    = (cnt == '0);
  assign full     = (cnt == FULL_CNT);
  assign usedw    = cnt;

  // A pop in the same cycle frees the slot, so a full queue can still accept.
  assign pop      = rd && !empty;
  assign accept   = wr && (!full || pop);
  assign overflow = wr && full && !pop;

  // Storage has no reset; stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      drop_cnt <= '0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({accept, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (overflow) begin
        drop_cnt <= sat_inc(drop_cnt);
      end
    end
  end

  assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/md_buffer.sv
// Metadata buffer: four independent FWFT queues feeding the gate-control scheduler.
module md_buffer
  import md_buffer_pkg::*;
#(
  parameter int    DEPTH_LOG2 = 5,
  parameter string PLATFORM   = "xilinx"
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [MD_W-1:0]       in_mb_md0,
  input  logic                  in_mb_md0_wr,
  input  logic [MD_W-1:0]       in_mb_md1,
  input  logic                  in_mb_md1_wr,
  input  logic [MD2_W-1:0]      in_mb_md2,
  input  logic                  in_mb_md2_wr,
  input  logic [MD_W-1:0]       in_mb_md3,
  input  logic                  in_mb_md3_wr,
  input  logic [3:0]            in_mb_rd,
  output logic [MD_W-1:0]       out_mb_md0,
  output logic [MD_W-1:0]       out_mb_md1,
  output logic [MD2_W-1:0]      out_mb_md2,
  output logic [MD_W-1:0]       out_mb_md3,
  output logic [3:0]            out_mb_empty,
  output logic [3:0]            out_mb_full,
  output logic [DEPTH_LOG2:0]   out_mb_usedw0,
  output logic [DEPTH_LOG2:0]   out_mb_usedw1,
  output logic [DEPTH_LOG2:0]   out_mb_usedw2,
  output logic [DEPTH_LOG2:0]   out_mb_usedw3,
  output logic [DROP_W-1:0]     out_mb_drop0,
  output logic [DROP_W-1:0]     out_mb_drop1,
  output logic [DROP_W-1:0]     out_mb_drop2,
  output logic [DROP_W-1:0]     out_mb_drop3
);

  // Every supported family maps the queues onto the same generic register RAM.
  if (PLATFORM == "xilinx") begin : g_xilinx_storage
  end

  md_fifo #(.WIDTH(MD_W), .DEPTH_LOG2(DEPTH_LOG2)) u_q_tsn_even (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_data  (in_mb_md0),
    .wr       (in_mb_md0_wr),
    .rd       (in_mb_rd[Q_TSN_EVEN]),
    .rd_data  (out_mb_md0),
    .empty    (out_mb_empty[Q_TSN_EVEN]),
    .full     (out_mb_full[Q_TSN_EVEN]),
    .usedw    (out_mb_usedw0),
    .drop_cnt (out_mb_drop0)
  );

  md_fifo #(.WIDTH(MD_W), .DEPTH_LOG2(DEPTH_LOG2)) u_q_tsn_odd (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_data  (in_mb_md1),
    .wr       (in_mb_md1_wr),
    .rd       (in_mb_rd[Q_TSN_ODD]),
    .rd_data  (out_mb_md1),
    .empty    (out_mb_empty[Q_TSN_ODD]),
    .full     (out_mb_full[Q_TSN_ODD]),
    .usedw    (out_mb_usedw1),
    .drop_cnt (out_mb_drop1)
  );

  // The token-cost field rides along untouched; only the scheduler interprets it.
  md_fifo #(.WIDTH(MD2_W), .DEPTH_LOG2(DEPTH_LOG2)) u_q_rc (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_data  (in_mb_md2),
    .wr       (in_mb_md2_wr),
    .rd       (in_mb_rd[Q_RC]),
    .rd_data  (out_mb_md2),
    .empty    (out_mb_empty[Q_RC]),
    .full     (out_mb_full[Q_RC]),
    .usedw    (out_mb_usedw2),
    .drop_cnt (out_mb_drop2)
  );

  md_fifo #(.WIDTH(MD_W), .DEPTH_LOG2(DEPTH_LOG2)) u_q_be (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_data  (in_mb_md3),
    .wr       (in_mb_md3_wr),
    .rd       (in_mb_rd[Q_BE]),
    .rd_data  (out_mb_md3),
    .empty    (out_mb_empty[Q_BE]),
    .full     (out_mb_full[Q_BE]),
    .usedw    (out_mb_usedw3),
    .drop_cnt (out_mb_drop3)
  );

endmodule
